rr_sel_arbiter16: RTL and testbench

//   Round-robin arbiter sharing one 16:1 single-bit mux path between 16 requesters.

---
 rtl/rr_sel_arbiter16.sv | 105 ++++++++++
 tb/tb_rr_sel_arbiter16.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter16.sv
// Round-robin arbiter that shares one 16:1 mux path between 16 requesters.
// Each grant is held until done, until the owner drops its request, or until the hold limit.
module rr_sel_arbiter16 #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] req_i,
    input  logic        done_i,
    output logic [15:0] gnt_o,
    output logic [3:0]  sel_o,
    output logic        valid_o,
    output logic        expired_o
);

    typedef enum logic {StIdle, StGrant} state_e;

    localparam bit               HoldEn   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [15:0]      gnt_q, gnt_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    logic [3:0]       winner;
    logic             any_req;
    logic             timeout;
    logic             owner_drop;
    logic             release_now;

    // First set request at or after ptr, wrapping through 15 back to ptr-1.
    always_comb begin
        winner  = 4'd0;
        any_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!any_req && req_i[ptr_q + 4'(i)]) begin
                winner  = ptr_q + 4'(i);
                any_req = 1'b1;
            end
        end
    end

    assign timeout     = HoldEn && (cnt_q == HoldLast);
    assign owner_drop  = !req_i[sel_q];
    assign release_now = done_i || owner_drop || timeout;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_d   = 16'h0001 << winner;
                    sel_d   = winner;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (release_now) begin
                    gnt_d     = '0;
                    ptr_d     = sel_q + 4'd1;
                    state_d   = StIdle;
                    // Flag only a pure timeout; a cooperative release at the limit is not an expiry.
                    expired_d = timeout && !done_i && !owner_drop;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign valid_o   = (state_q == StGrant);
    assign expired_o = expired_q;

endmodule

// File: tb/tb_rr_sel_arbiter16.sv
// Self-checking bench for rr_sel_arbiter16: expected grant indices go into a scoreboard
// queue as stimulus is applied and are compared when each grant appears.
module tb_rr_sel_arbiter16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] req_i = '0;
    logic        done_i = 1'b0;
    logic [15:0] gnt_o;
    logic [3:0]  sel_o;
    logic        valid_o;
    logic        expired_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_sel_q[$];

    rr_sel_arbiter16 #(
        .HOLD_MAX(8),
        .CNT_W   (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .done_i   (done_i),
        .gnt_o    (gnt_o),
        .sel_o    (sel_o),
        .valid_o  (valid_o),
        .expired_o(expired_o)
    );

    always #5 clk_i = ~clk_i;

    // Structural invariants, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            n_checks++;
            if (valid_o !== (|gnt_o) || (valid_o && gnt_o !== (16'h0001 << sel_o))) begin
                n_fail++;
                $display("FAIL invariant: gnt=%h sel=%0d valid=%b", gnt_o, sel_o, valid_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!valid_o && waited < 40) begin
            tick();
            waited++;
        end
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        req_i  = '0;
        done_i = 1'b0;
        exp_sel_q.delete();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic check_grant(input string name);
        int e;
        n_checks++;
        if (!valid_o) begin
            n_fail++;
            $display("FAIL %s timeout: valid=%b required 1", name, valid_o);
        end else if (exp_sel_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected grant: sel=%0d, scoreboard empty", name, sel_o);
        end else begin
            e = exp_sel_q.pop_front();
            if (sel_o !== 4'(e) || gnt_o !== (16'h0001 << e)) begin
                n_fail++;
                $display("FAIL %s grant: sel=%0d gnt=%h required sel=%0d", name, sel_o, gnt_o, e);
            end
        end
    endtask

    task automatic test_reset();
        int w;
        rst_i  = 1'b1;
        req_i  = 16'hFFFF;
        done_i = 1'b0;
        exp_sel_q.delete();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (gnt_o !== 16'h0 || sel_o !== 4'd0 || valid_o !== 1'b0 || expired_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: gnt=%h sel=%0d valid=%b expired=%b required 0",
                         gnt_o, sel_o, valid_o, expired_o);
            end
        end
        exp_sel_q.push_back(0);
        rst_i = 1'b0;
        wait_valid(w);
        n_checks++;
        if (w !== 1) begin
            n_fail++;
            $display("FAIL reset_first_latency: waited=%0d required 1", w);
        end
        check_grant("reset_first");
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        req_i  = '0;
        tick();
    endtask

    task automatic test_single();
        int w;
        do_reset();
        req_i = 16'h0020;
        exp_sel_q.push_back(5);
        tick();
        check_grant("single");
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        req_i  = '0;
        n_checks++;
        if (valid_o !== 1'b0 || gnt_o !== 16'h0 || expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: valid=%b gnt=%h expired=%b required 0 0 0",
                     valid_o, gnt_o, expired_o);
        end
        wait_valid(w);
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: valid=%b required 0 with no requests", valid_o);
        end
    endtask

    task automatic test_rotation();
        int w;
        do_reset();
        for (int k = 0; k <= 16; k++) exp_sel_q.push_back(k % 16);
        req_i = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            wait_valid(w);
            n_checks++;
            if (w !== 1) begin
                n_fail++;
                $display("FAIL rotation_gap: grant %0d waited=%0d required 1", k, w);
            end
            check_grant("rotation");
            done_i = 1'b1;
            tick();
            done_i = 1'b0;
            n_checks++;
            if (valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rotation_bubble: valid=%b required 0 after grant %0d", valid_o, k);
            end
        end
        req_i = '0;
        tick();
    endtask

    task automatic test_timeout();
        int w;
        int cycles;
        do_reset();
        exp_sel_q.push_back(0);
        exp_sel_q.push_back(15);
        req_i = 16'h8001;
        wait_valid(w);
        check_grant("timeout_first");
        cycles = 1;
        while (valid_o && cycles < 20) begin
            n_checks++;
            if (expired_o !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early_expired: expired=%b required 0 at cycle %0d",
                         expired_o, cycles);
            end
            tick();
            if (valid_o) cycles++;
        end
        n_checks++;
        if (cycles !== 8) begin
            n_fail++;
            $display("FAIL timeout_length: held=%0d required 8", cycles);
        end
        n_checks++;
        if (expired_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_expired: expired=%b required 1", expired_o);
        end
        tick();
        n_checks++;
        if (expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse_width: expired=%b required 0", expired_o);
        end
        check_grant("timeout_next");
        req_i = '0;
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_drop: valid=%b expired=%b required 0 0", valid_o, expired_o);
        end
    endtask

    task automatic test_done_timeout();
        int w;
        do_reset();
        exp_sel_q.push_back(0);
        exp_sel_q.push_back(0);
        req_i = 16'h0001;
        wait_valid(w);
        check_grant("done_timeout_first");
        for (int c = 0; c < 7; c++) tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_timeout_release: valid=%b expired=%b required 0 0",
                     valid_o, expired_o);
        end
        tick();
        check_grant("lone_regrant");
        req_i = '0;
        tick();
    endtask

    task automatic test_drop();
        int w;
        do_reset();
        exp_sel_q.push_back(0);
        exp_sel_q.push_back(1);
        req_i = 16'h0003;
        wait_valid(w);
        check_grant("drop_first");
        tick();
        req_i = 16'h0002;
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_release: valid=%b expired=%b required 0 0", valid_o, expired_o);
        end
        req_i = 16'h0003;
        tick();
        check_grant("drop_ptr");
        req_i = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        exp_sel_q.push_back(0);
        exp_sel_q.push_back(9);
        exp_sel_q.push_back(0);
        req_i = 16'h0001;
        wait_valid(w);
        check_grant("mid_setup");
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        req_i  = 16'h0200;
        wait_valid(w);
        check_grant("mid_owner");
        tick();
        rst_i = 1'b1;
        req_i = 16'h0201;
        tick();
        n_checks++;
        if (gnt_o !== 16'h0 || valid_o !== 1'b0 || sel_o !== 4'd0 || expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: gnt=%h valid=%b sel=%0d expired=%b required 0",
                     gnt_o, valid_o, sel_o, expired_o);
        end
        rst_i = 1'b0;
        wait_valid(w);
        check_grant("mid_after_reset");
        req_i = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_done_timeout();
        test_drop();
        test_reset_mid();
        n_checks++;
        if (exp_sel_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_sel_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
